// File: rtl/alu_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// alu_arbiter_pkg : shared types and constants for the ALU arbiter slice
// Revision: 1.0
// ============================================================================
package alu_arbiter_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0011
  } alu_op_t;

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// alu_arbiter_if : per-requester request/response bundle for the ALU arbiter
// Revision: 1.0
// ============================================================================
interface alu_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = 4
);
  localparam int DW = alu_arbiter_pkg::DATA_W;

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*4-1:0]     req_op;
  logic [NUM_REQ*DW-1:0]    req_a;
  logic [NUM_REQ*DW-1:0]    req_b;
  logic [NUM_REQ*TAG_W-1:0] req_tag;
  logic [NUM_REQ-1:0]       req_lock;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [NUM_REQ-1:0]       rsp_ready;
  logic [NUM_REQ*DW-1:0]    rsp_result;
  logic [NUM_REQ-1:0]       rsp_zero;
  logic [NUM_REQ*TAG_W-1:0] rsp_tag;

  modport master (
    output req_valid, req_op, req_a, req_b, req_tag, req_lock, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_tag
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_tag, req_lock, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_tag
  );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter_alu.sv
`default_nettype none
// ============================================================================
// alu : combinational AND/OR/ADD/SUB unit; unknown opcodes yield zero
// Revision: 1.0
// ============================================================================
module alu
  import alu_arbiter_pkg::*;
(
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              zero
);
  always_comb begin
    result = '0;
    case (op)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      default: result = '0;
    endcase
    zero = (result == '0);
  end
endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// alu_arbiter : round-robin sharing of one ALU with optional grant lock and
//               a one-entry registered response per requester
// Revision: 1.0
// ============================================================================
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int TAG_W    = 4,
  parameter int LOCK_MAX = 8,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
)(
  input  logic             clk,
  input  logic             rst_n,
  alu_arbiter_if.slave     bus,
  output logic             lock_active,
  output logic [IDX_W-1:0] lock_owner
);
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  arb_state_t               r_state, w_state_nxt;
  logic [IDX_W-1:0]         r_last, w_last_nxt, r_owner, w_owner_nxt;
  logic [CNT_W-1:0]         r_cnt, w_cnt_nxt;
  logic [NUM_REQ-1:0]       w_elig, w_req_ready;
  logic [IDX_W:0]           w_pick;
  logic                     w_gnt_vld, w_lock, w_zero;
  logic [IDX_W-1:0]         w_gnt;
  logic [3:0]               w_op;
  logic [DATA_W-1:0]        w_a, w_b, w_res;
  logic [NUM_REQ-1:0]       r_rsp_valid, r_rsp_zero;
  logic [NUM_REQ*DATA_W-1:0] r_rsp_result;
  logic [NUM_REQ*TAG_W-1:0] r_rsp_tag;

  // Scan far-to-near so the nearest eligible index after `last` wins.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] elig,
                                             input logic [IDX_W-1:0]   last);
    logic [IDX_W:0] res;
    int idx;
    res = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (elig[idx]) res = {1'b1, IDX_W'(idx)};
    end
    return res;
  endfunction

  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_elig[i] = bus.req_valid[i] && (!r_rsp_valid[i] || bus.rsp_ready[i]) &&
                  ((r_state == ARB) || (r_owner == IDX_W'(i)));
    end
  end

  // No grant is issued while reset is held, so nothing can look accepted.
  assign w_pick      = rr_pick(w_elig, r_last);
  assign w_gnt_vld   = w_pick[IDX_W] && rst_n;
  assign w_gnt       = w_pick[IDX_W-1:0];
  assign w_req_ready = w_gnt_vld ? (NUM_REQ'(1) << w_gnt) : '0;

  always_comb begin
    w_op   = '0;
    w_a    = '0;
    w_b    = '0;
    w_lock = 1'b0;
    if (w_gnt_vld) begin
      w_op   = bus.req_op[int'(w_gnt)*4 +: 4];
      w_a    = bus.req_a[int'(w_gnt)*DATA_W +: DATA_W];
      w_b    = bus.req_b[int'(w_gnt)*DATA_W +: DATA_W];
      w_lock = bus.req_lock[w_gnt];
    end
  end

  alu u_alu (
    .op     (w_op),
    .a      (w_a),
    .b      (w_b),
    .result (w_res),
    .zero   (w_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB;
      r_last  <= IDX_W'(NUM_REQ - 1);
      r_owner <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_owner <= w_owner_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_owner_nxt = r_owner;
    w_cnt_nxt   = r_cnt;
    if (w_gnt_vld) w_last_nxt = w_gnt;
    case (r_state)
      ARB: begin
        if (w_gnt_vld && w_lock) begin
          w_state_nxt = LOCKED;
          w_owner_nxt = w_gnt;
          w_cnt_nxt   = '0;
        end
      end
      LOCKED: begin
        if (w_gnt_vld) begin
          w_cnt_nxt = '0;
          if (!w_lock) w_state_nxt = ARB;
        end else if (r_cnt == CNT_W'(LOCK_MAX - 1)) begin
          w_state_nxt = ARB;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = ARB;
    endcase
  end

  // A fill in the same cycle as a drain wins, keeping one op/cycle throughput.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid  <= '0;
      r_rsp_zero   <= '0;
      r_rsp_result <= '0;
      r_rsp_tag    <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_req_ready[i]) begin
          r_rsp_valid[i]                   <= 1'b1;
          r_rsp_zero[i]                    <= w_zero;
          r_rsp_result[i*DATA_W +: DATA_W] <= w_res;
          r_rsp_tag[i*TAG_W +: TAG_W]      <= bus.req_tag[i*TAG_W +: TAG_W];
        end else if (bus.rsp_ready[i]) begin
          r_rsp_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_zero   = r_rsp_zero;
  assign bus.rsp_result = r_rsp_result;
  assign bus.rsp_tag    = r_rsp_tag;
  assign lock_active    = (r_state == LOCKED);
  assign lock_owner     = (r_state == LOCKED) ? r_owner : '0;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// tb_alu_arbiter : directed self-checking bench for alu_arbiter (2 requesters)
// Revision: 1.0
// ============================================================================
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       lock_active;
  logic [0:0] lock_owner;
  int         n_cmp = 0;
  int         n_err = 0;

  alu_arbiter_if #(.NUM_REQ(2), .TAG_W(4)) bif ();

  alu_arbiter #(.NUM_REQ(2), .TAG_W(4), .LOCK_MAX(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bif),
    .lock_active (lock_active),
    .lock_owner  (lock_owner)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive(input int i, input logic v, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] tag, input logic lock);
    bif.req_valid[i]     = v;
    bif.req_op[i*4 +: 4] = op;
    bif.req_a[i*32 +: 32] = a;
    bif.req_b[i*32 +: 32] = b;
    bif.req_tag[i*4 +: 4] = tag;
    bif.req_lock[i]      = lock;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bif.rsp_ready = 2'b00;
    drive(0, 0, 4'h0, 0, 0, 0, 0);
    drive(1, 0, 4'h0, 0, 0, 0, 0);
    @(negedge clk); #1;
    n_cmp++; if (bif.rsp_valid !== 2'b00) begin n_err++; $display("FAIL reset_rsp_valid got %b exp 00", bif.rsp_valid); end
    n_cmp++; if (bif.req_ready !== 2'b00) begin n_err++; $display("FAIL reset_req_ready got %b exp 00", bif.req_ready); end
    n_cmp++; if (lock_active !== 1'b0) begin n_err++; $display("FAIL reset_lock_active got %b exp 0", lock_active); end
    n_cmp++; if (lock_owner !== 1'b0) begin n_err++; $display("FAIL reset_lock_owner got %b exp 0", lock_owner); end
    n_cmp++; if (bif.rsp_result !== 64'h0) begin n_err++; $display("FAIL reset_rsp_result got %h exp 0", bif.rsp_result); end
    n_cmp++; if (bif.rsp_tag !== 8'h0 || bif.rsp_zero !== 2'b00) begin n_err++; $display("FAIL reset_rsp_tag_zero got %h/%b exp 0/00", bif.rsp_tag, bif.rsp_zero); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk);
    bif.rsp_ready = 2'b11;
    drive(0, 1, OP_ADD, 32'd5, 32'd7, 4'd3, 0);
    #1;
    n_cmp++; if (bif.req_ready !== 2'b01) begin n_err++; $display("FAIL single_ready got %b exp 01", bif.req_ready); end
    @(negedge clk);
    n_cmp++; if (bif.rsp_valid !== 2'b01) begin n_err++; $display("FAIL single_rsp_valid got %b exp 01", bif.rsp_valid); end
    n_cmp++; if (bif.rsp_result[31:0] !== 32'd12) begin n_err++; $display("FAIL single_result got %h exp 0000000c", bif.rsp_result[31:0]); end
    n_cmp++; if (bif.rsp_zero[0] !== 1'b0) begin n_err++; $display("FAIL single_zero got %b exp 0", bif.rsp_zero[0]); end
    n_cmp++; if (bif.rsp_tag[3:0] !== 4'd3) begin n_err++; $display("FAIL single_tag got %h exp 3", bif.rsp_tag[3:0]); end
    drive(0, 0, 4'h0, 0, 0, 0, 0);
  endtask

  // Back-to-back ops on requester 0; each response checked one cycle later.
  task automatic test_arith();
    logic [3:0]  ops [6] = '{OP_SUB, OP_SUB, OP_ADD, 4'hF, OP_AND, OP_OR};
    logic [31:0] va  [6] = '{32'd3, 32'd0, 32'hFFFF_FFFF, 32'd5, 32'h0000_F0F0, 32'h0000_F0F0};
    logic [31:0] vb  [6] = '{32'd3, 32'd1, 32'd1, 32'd6, 32'h0000_FF00, 32'h0000_0F0F};
    logic [31:0] er  [6] = '{32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'h0000_F000, 32'h0000_FFFF};
    logic        ez  [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      if (k > 0) begin
        n_cmp++; if (bif.rsp_valid[0] !== 1'b1 || bif.rsp_result[31:0] !== er[k-1])
          begin n_err++; $display("FAIL arith_result[%0d] got v=%b %h exp v=1 %h", k-1, bif.rsp_valid[0], bif.rsp_result[31:0], er[k-1]); end
        n_cmp++; if (bif.rsp_zero[0] !== ez[k-1] || bif.rsp_tag[3:0] !== 4'(k-1))
          begin n_err++; $display("FAIL arith_zero_tag[%0d] got %b/%h exp %b/%h", k-1, bif.rsp_zero[0], bif.rsp_tag[3:0], ez[k-1], 4'(k-1)); end
      end
      if (k < 6) begin
        drive(0, 1, ops[k], va[k], vb[k], 4'(k), 0);
        #1;
        n_cmp++; if (bif.req_ready !== 2'b01) begin n_err++; $display("FAIL arith_ready[%0d] got %b exp 01", k, bif.req_ready); end
      end else begin
        drive(0, 0, 4'h0, 0, 0, 0, 0);
      end
    end
  endtask

  // Entered with last grant = 0, so requester 1 is served first.
  task automatic test_round_robin();
    logic [1:0]  exp_rdy [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
    int          exp_g   [4] = '{1, 0, 1, 0};
    logic [31:0] exp_res [4] = '{32'd100, 32'd101, 32'd98, 32'd103};
    logic [3:0]  exp_tag [4] = '{4'h5, 4'hA, 4'h5, 4'hA};
    int g;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      if (k > 0) begin
        g = exp_g[k-1];
        n_cmp++; if (bif.rsp_valid !== exp_rdy[k-1]) begin n_err++; $display("FAIL rr_rsp_valid[%0d] got %b exp %b", k-1, bif.rsp_valid, exp_rdy[k-1]); end
        n_cmp++; if (bif.rsp_result[g*32 +: 32] !== exp_res[k-1] || bif.rsp_tag[g*4 +: 4] !== exp_tag[k-1])
          begin n_err++; $display("FAIL rr_rsp[%0d] got %h/%h exp %h/%h", k-1, bif.rsp_result[g*32 +: 32], bif.rsp_tag[g*4 +: 4], exp_res[k-1], exp_tag[k-1]); end
      end
      if (k < 4) begin
        drive(0, 1, OP_ADD, 32'(k), 32'd100, 4'hA, 0);
        drive(1, 1, OP_SUB, 32'd100, 32'(k), 4'h5, 0);
        #1;
        n_cmp++; if (bif.req_ready !== exp_rdy[k]) begin n_err++; $display("FAIL rr_ready[%0d] got %b exp %b", k, bif.req_ready, exp_rdy[k]); end
      end else begin
        drive(0, 0, 4'h0, 0, 0, 0, 0);
        drive(1, 0, 4'h0, 0, 0, 0, 0);
      end
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    bif.rsp_ready = 2'b10;
    drive(0, 1, OP_ADD, 32'd10, 32'd20, 4'd7, 0);
    #1;
    n_cmp++; if (bif.req_ready !== 2'b01) begin n_err++; $display("FAIL bp_fill_ready got %b exp 01", bif.req_ready); end
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      if (k > 0) begin
        n_cmp++; if (bif.rsp_valid[1] !== 1'b1 || bif.rsp_result[63:32] !== 32'(50 - (k-1)))
          begin n_err++; $display("FAIL bp_rsp1[%0d] got v=%b %h exp v=1 %h", k-1, bif.rsp_valid[1], bif.rsp_result[63:32], 32'(50 - (k-1))); end
      end
      if (k < 3) begin
        drive(0, 1, OP_ADD, 32'd1, 32'd1, 4'd2, 0);
        drive(1, 1, OP_SUB, 32'd50, 32'(k), 4'd9, 0);
        #1;
        n_cmp++; if (bif.req_ready !== 2'b10) begin n_err++; $display("FAIL bp_ready[%0d] got %b exp 10", k, bif.req_ready); end
        n_cmp++; if (bif.rsp_valid[0] !== 1'b1 || bif.rsp_result[31:0] !== 32'd30 || bif.rsp_tag[3:0] !== 4'd7)
          begin n_err++; $display("FAIL bp_hold0[%0d] got v=%b %h/%h exp v=1 0000001e/7", k, bif.rsp_valid[0], bif.rsp_result[31:0], bif.rsp_tag[3:0]); end
      end else begin
        bif.rsp_ready = 2'b11;
        drive(1, 0, 4'h0, 0, 0, 0, 0);
        #1;
        n_cmp++; if (bif.req_ready !== 2'b01) begin n_err++; $display("FAIL bp_release_ready got %b exp 01", bif.req_ready); end
      end
    end
    @(negedge clk);
    n_cmp++; if (bif.rsp_result[31:0] !== 32'd2 || bif.rsp_tag[3:0] !== 4'd2)
      begin n_err++; $display("FAIL bp_refill0 got %h/%h exp 00000002/2", bif.rsp_result[31:0], bif.rsp_tag[3:0]); end
    drive(0, 0, 4'h0, 0, 0, 0, 0);
  endtask

  // Cycles 0-3: requester 1 holds the lock; cycle 4: requester 0 locks then idles 8 cycles.
  task automatic test_lock();
    logic [1:0] exp_rdy;
    logic       exp_la;
    logic       exp_own;
    bif.rsp_ready = 2'b11;
    for (int c = 0; c <= 13; c++) begin
      @(negedge clk);
      if (c <= 4) drive(0, 1, OP_OR, 32'd1, 32'd2, 4'h0, (c == 4));
      else        drive(0, 0, 4'h0, 0, 0, 0, 0);
      drive(1, (c != 4) || 1'b1, OP_AND, 32'hFF, 32'h0F, 4'h1, (c < 3));
      exp_rdy = (c <= 3 || c == 13) ? 2'b10 : (c == 4) ? 2'b01 : 2'b00;
      exp_la  = (c >= 1 && c <= 3) || (c >= 5 && c <= 12);
      exp_own = (c >= 1 && c <= 3);
      #1;
      n_cmp++; if (bif.req_ready !== exp_rdy) begin n_err++; $display("FAIL lock_ready[c%0d] got %b exp %b", c, bif.req_ready, exp_rdy); end
      n_cmp++; if (lock_active !== exp_la || lock_owner !== exp_own)
        begin n_err++; $display("FAIL lock_state[c%0d] got act=%b own=%b exp act=%b own=%b", c, lock_active, lock_owner, exp_la, exp_own); end
    end
    @(negedge clk);
    drive(0, 0, 4'h0, 0, 0, 0, 0);
    drive(1, 0, 4'h0, 0, 0, 0, 0);
  endtask

  // Entered with last grant = 1: requester 0 locks and its response stays full.
  task automatic test_reset_mid();
    @(negedge clk);
    bif.rsp_ready = 2'b00;
    drive(0, 1, OP_ADD, 32'd4, 32'd4, 4'd1, 1);
    drive(1, 1, OP_ADD, 32'd1, 32'd1, 4'd2, 0);
    #1;
    n_cmp++; if (bif.req_ready !== 2'b01) begin n_err++; $display("FAIL mid_pre_ready got %b exp 01", bif.req_ready); end
    @(negedge clk); #1;
    n_cmp++; if (bif.req_ready !== 2'b00 || lock_active !== 1'b1 || bif.rsp_valid !== 2'b01)
      begin n_err++; $display("FAIL mid_pre_state got rdy=%b act=%b vld=%b exp 00/1/01", bif.req_ready, lock_active, bif.rsp_valid); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bif.rsp_valid !== 2'b00 || lock_active !== 1'b0 || bif.req_ready !== 2'b00)
      begin n_err++; $display("FAIL mid_reset got vld=%b act=%b rdy=%b exp 00/0/00", bif.rsp_valid, lock_active, bif.req_ready); end
    n_cmp++; if (bif.rsp_result !== 64'h0) begin n_err++; $display("FAIL mid_reset_result got %h exp 0", bif.rsp_result); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bif.rsp_ready = 2'b11;
    #1;
    n_cmp++; if (bif.req_ready !== 2'b01) begin n_err++; $display("FAIL mid_first_grant got %b exp 01", bif.req_ready); end
    @(negedge clk);
    drive(0, 0, 4'h0, 0, 0, 0, 0);
    drive(1, 0, 4'h0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_arith();
    test_round_robin();
    test_backpressure();
    test_lock();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
